// File: rtl/rule_filter_avlstrm_pkg.sv
// Shared types for the rule filter: metadata beat layout, num_rules field
// position and FSM state encoding.
package struct_s;

  typedef struct packed {
    logic [31:0] flow_id;
    logic [15:0] pkt_len;
    logic [15:0] num_rules;
  } metadata_t;

  localparam int META_W        = $bits(metadata_t);
  localparam int NUM_RULES_LSB = 0;
  localparam int NUM_RULES_MSB = 15;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_META = 3'd1;
  localparam logic [2:0] ST_RULE = 3'd2;
  localparam logic [2:0] ST_PKT  = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  typedef enum logic [2:0] {
    RF_IDLE = ST_IDLE,
    RF_META = ST_META,
    RF_RULE = ST_RULE,
    RF_PKT  = ST_PKT,
    RF_DROP = ST_DROP
  } rf_state_t;

  // Extract the rule count from a raw metadata beat.
  function automatic logic [15:0] get_num_rules(input logic [META_W-1:0] beat);
    return beat[NUM_RULES_MSB:NUM_RULES_LSB];
  endfunction

endpackage

// File: rtl/avl_stream_if.sv
// Avalon-ST style stream bundle: valid/ready (ready latency 0), sop/eop/empty.
interface avl_stream_if #(
  parameter int W       = 512,
  parameter int EMPTY_W = 6
) ();
  logic               valid;
  logic               ready;
  logic [W-1:0]       data;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;

  modport rx (input valid, data, sop, eop, empty, output ready);
  modport tx (output valid, data, sop, eop, empty, input ready);
endinterface

// File: rtl/rule_filter_avlstrm_stats_cnt.sv
// 32-bit enable-increment counter with synchronous active-low clear.
// Wraps modulo 2^32.
module rf_stats_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  // Count enabled events, clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (en) begin
      count <= count + 32'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/rule_filter_avlstrm.sv
// rule_filter_avlstrm: drops packets whose metadata reports zero matched
// rules, forwards the rest as metadata -> rules -> packet.
// Optional build macro RULE_FILTER_STATS_EN enables the statistics counters;
// without it all stats_* outputs read zero.
module rule_filter_avlstrm #(
  parameter int PKT_W  = 512,
  parameter int USR_W  = 512,
  parameter int META_W = struct_s::META_W
) (
  input  logic        Clk,
  input  logic        Rst_n,
  avl_stream_if.rx    in_pkt,
  avl_stream_if.rx    in_meta,
  avl_stream_if.rx    in_usr,
  avl_stream_if.tx    out_pkt,
  avl_stream_if.tx    out_meta,
  avl_stream_if.tx    out_usr,
  output logic [31:0] stats_in_pkt,
  output logic [31:0] stats_drop_pkt,
  output logic [31:0] stats_fwd_pkt,
  output logic [31:0] stats_fwd_rule
);
  import struct_s::*;

  rf_state_t state_r;
  rf_state_t state_nxt;
  metadata_t meta_r;
  logic      run_r;
  logic      meta_xfer;
  logic      usr_xfer;
  logic      pkt_fwd_xfer;
  logic      pkt_drop_xfer;
  logic      unused_meta_bits;

  // Metadata is always a single beat; its framing bits carry no information.
  assign unused_meta_bits = ^{in_meta.sop, in_meta.eop, in_meta.empty, in_meta.data};

  assign meta_xfer     = in_meta.valid && in_meta.ready;
  assign usr_xfer      = out_usr.valid && out_usr.ready;
  assign pkt_fwd_xfer  = (state_r == RF_PKT) && in_pkt.valid && out_pkt.ready;
  assign pkt_drop_xfer = (state_r == RF_DROP) && in_pkt.valid;

  // Upstream ready per state; run_r keeps all readies low while in reset.
  always_comb begin
    in_meta.ready = 1'b0;
    in_usr.ready  = 1'b0;
    in_pkt.ready  = 1'b0;
    case (state_r)
      RF_IDLE: in_meta.ready = run_r;
      RF_RULE: in_usr.ready  = out_usr.ready;
      RF_PKT:  in_pkt.ready  = out_pkt.ready;
      RF_DROP: in_pkt.ready  = 1'b1;
      default: in_meta.ready = 1'b0;
    endcase
  end

  // Latched metadata is presented as a single-beat packet in META.
  always_comb begin
    out_meta.valid              = (state_r == RF_META);
    out_meta.data               = '0;
    out_meta.data[META_W-1:0]   = meta_r;
    out_meta.sop                = (state_r == RF_META);
    out_meta.eop                = (state_r == RF_META);
    out_meta.empty              = '0;
  end

  // Rule stream passes straight through while in RULE, zero otherwise.
  always_comb begin
    out_usr.valid = 1'b0;
    out_usr.data  = '0;
    out_usr.sop   = 1'b0;
    out_usr.eop   = 1'b0;
    out_usr.empty = '0;
    if (state_r == RF_RULE) begin
      out_usr.valid             = in_usr.valid;
      out_usr.data[USR_W-1:0]   = in_usr.data[USR_W-1:0];
      out_usr.sop               = in_usr.sop;
      out_usr.eop               = in_usr.eop;
      out_usr.empty             = in_usr.empty;
    end else begin
      out_usr.valid = 1'b0;
    end
  end

  // Packet stream passes straight through while in PKT; DROP sinks it.
  always_comb begin
    out_pkt.valid = 1'b0;
    out_pkt.data  = '0;
    out_pkt.sop   = 1'b0;
    out_pkt.eop   = 1'b0;
    out_pkt.empty = '0;
    if (state_r == RF_PKT) begin
      out_pkt.valid             = in_pkt.valid;
      out_pkt.data[PKT_W-1:0]   = in_pkt.data[PKT_W-1:0];
      out_pkt.sop               = in_pkt.sop;
      out_pkt.eop               = in_pkt.eop;
      out_pkt.empty             = in_pkt.empty;
    end else begin
      out_pkt.valid = 1'b0;
    end
  end

  // Next-state: advance on transferred beats only, so back-pressure stalls.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      RF_IDLE: begin
        if (meta_xfer) begin
          state_nxt = (get_num_rules(in_meta.data[META_W-1:0]) == 16'd0) ? RF_DROP : RF_META;
        end else begin
          state_nxt = RF_IDLE;
        end
      end
      RF_META: state_nxt = out_meta.ready ? RF_RULE : RF_META;
      RF_RULE: state_nxt = (usr_xfer && in_usr.eop) ? RF_PKT : RF_RULE;
      RF_PKT:  state_nxt = (pkt_fwd_xfer && in_pkt.eop) ? RF_IDLE : RF_PKT;
      RF_DROP: state_nxt = (pkt_drop_xfer && in_pkt.eop) ? RF_IDLE : RF_DROP;
      default: state_nxt = RF_IDLE;
    endcase
  end

  // State, metadata latch and post-reset run flag.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r <= RF_IDLE;
      meta_r  <= '0;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      run_r   <= 1'b1;
      if (meta_xfer) begin
        meta_r <= metadata_t'(in_meta.data[META_W-1:0]);
      end
    end
  end

`ifdef RULE_FILTER_STATS_EN
  rf_stats_cnt u_cnt_in (
    .clk(Clk), .rst_n(Rst_n), .en(meta_xfer), .count(stats_in_pkt)
  );
  rf_stats_cnt u_cnt_drop (
    .clk(Clk), .rst_n(Rst_n), .en(pkt_drop_xfer && in_pkt.eop), .count(stats_drop_pkt)
  );
  rf_stats_cnt u_cnt_fwd (
    .clk(Clk), .rst_n(Rst_n), .en(pkt_fwd_xfer && in_pkt.eop), .count(stats_fwd_pkt)
  );
  rf_stats_cnt u_cnt_rule (
    .clk(Clk), .rst_n(Rst_n), .en(usr_xfer), .count(stats_fwd_rule)
  );
`else
  assign stats_in_pkt   = 32'd0;
  assign stats_drop_pkt = 32'd0;
  assign stats_fwd_pkt  = 32'd0;
  assign stats_fwd_rule = 32'd0;
`endif

endmodule

// File: tb/tb_rule_filter_avlstrm.sv
// Scoreboard bench for rule_filter_avlstrm. Stimulus pushes expected beats
// into queues; a negedge monitor pops and compares on every output transfer.
module tb_rule_filter_avlstrm;
  import struct_s::*;

  localparam int PKT_W = 512;
  localparam int USR_W = 512;

  typedef struct packed {
    logic [PKT_W-1:0] data;
    logic             sop;
    logic             eop;
    logic [5:0]       empty;
  } pbeat_t;

  typedef struct packed {
    logic [USR_W-1:0] data;
    logic             sop;
    logic             eop;
  } ubeat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] s_in, s_drop, s_fwd, s_rule;

  avl_stream_if #(.W(PKT_W))  in_pkt_if  ();
  avl_stream_if #(.W(META_W)) in_meta_if ();
  avl_stream_if #(.W(USR_W))  in_usr_if  ();
  avl_stream_if #(.W(PKT_W))  out_pkt_if ();
  avl_stream_if #(.W(META_W)) out_meta_if ();
  avl_stream_if #(.W(USR_W))  out_usr_if ();

  rule_filter_avlstrm #(.PKT_W(PKT_W), .USR_W(USR_W), .META_W(META_W)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .in_pkt(in_pkt_if), .in_meta(in_meta_if), .in_usr(in_usr_if),
    .out_pkt(out_pkt_if), .out_meta(out_meta_if), .out_usr(out_usr_if),
    .stats_in_pkt(s_in), .stats_drop_pkt(s_drop),
    .stats_fwd_pkt(s_fwd), .stats_fwd_rule(s_rule)
  );

  always #5 clk = ~clk;

  logic [META_W-1:0] q_meta[$];
  ubeat_t            q_usr[$];
  pbeat_t            q_pkt[$];
  int meta_cyc[$], usr_cyc[$], pkt_cyc[$];

  int n_checks = 0, n_fail = 0, cyc = 0;
  int exp_in = 0, exp_drop = 0, exp_fwd = 0, exp_rule = 0;
  int drv_meta_cyc = 0, pkt_rdy_cnt = 0, usr_xfer_cnt = 0, pkt_xfer_cnt = 0, usr_stall_cnt = 0;
  logic rnd_rdy = 1'b0, hold_usr = 1'b0, abort = 1'b0, sp_done = 1'b0;
  logic usr_hold = 1'b0;
  logic [USR_W-1:0] usr_prev = '0;

  task automatic chk(input string nm, input logic [519:0] act, input logic [519:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [519:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s_unexpected: got beat %h, expected no output", nm, act);
  endtask

  function automatic logic [31:0] se(input int v);
    logic [31:0] r;
    r = 32'(v);
`ifndef RULE_FILTER_STATS_EN
    r = 32'd0;
`endif
    return r;
  endfunction

  function automatic ubeat_t mk_usr(input int idx, input int b, input int nb);
    ubeat_t u;
    u.data = {32{16'(idx * 4 + b)}};
    u.sop  = (b == 0);
    u.eop  = (b == nb - 1);
    return u;
  endfunction

  function automatic pbeat_t mk_pkt(input int idx, input int b, input int nb, input int emp);
    pbeat_t p;
    p.data  = {16{32'(idx * 256 + b)}};
    p.sop   = (b == 0);
    p.eop   = (b == nb - 1);
    p.empty = p.eop ? 6'(emp) : 6'd0;
    return p;
  endfunction

  // Clock-cycle counter shared by drivers and monitor
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready generator
  initial forever begin
    @(posedge clk);
    #1;
    out_meta_if.ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    out_usr_if.ready  = hold_usr ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    out_pkt_if.ready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops and compares whenever an output beat transfers
  initial forever begin
    ubeat_t ub;
    pbeat_t pb;
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (out_meta_if.valid && out_meta_if.ready) begin
        meta_cyc.push_back(cyc);
        if (q_meta.size() == 0) unexpected("meta", 520'(out_meta_if.data));
        else chk("meta_beat", 520'(out_meta_if.data), 520'(q_meta.pop_front()));
      end
      if (usr_hold) chk("usr_hold", 520'({out_usr_if.valid, out_usr_if.data}), 520'({1'b1, usr_prev}));
      usr_hold = out_usr_if.valid && !out_usr_if.ready;
      usr_prev = out_usr_if.data;
      if (usr_hold) usr_stall_cnt++;
      if (out_usr_if.valid && out_usr_if.ready) begin
        usr_xfer_cnt++;
        usr_cyc.push_back(cyc);
        if (q_usr.size() == 0) unexpected("usr", 520'(out_usr_if.data));
        else begin
          ub = q_usr.pop_front();
          chk("usr_beat", 520'({out_usr_if.data, out_usr_if.sop, out_usr_if.eop}), 520'(ub));
        end
      end
      if (out_pkt_if.valid && out_pkt_if.ready) begin
        pkt_xfer_cnt++;
        pkt_cyc.push_back(cyc);
        if (q_pkt.size() == 0) unexpected("pkt", 520'(out_pkt_if.data));
        else begin
          pb = q_pkt.pop_front();
          chk("pkt_beat", 520'({out_pkt_if.data, out_pkt_if.sop, out_pkt_if.eop, out_pkt_if.empty}), 520'(pb));
        end
      end
      if (in_pkt_if.ready === 1'b1) pkt_rdy_cnt++;
    end else begin
      usr_hold = 1'b0;
    end
  end

  // Wait for a transfer on input stream 0=meta 1=usr 2=pkt
  task automatic wait_hs(input int which, output int at_cyc);
    int t;
    logic done;
    t = 0;
    done = 1'b0;
    at_cyc = -1;
    while (!done && !abort) begin
      @(negedge clk);
      case (which)
        0: done = (in_meta_if.ready === 1'b1);
        1: done = (in_usr_if.ready === 1'b1);
        default: done = (in_pkt_if.ready === 1'b1);
      endcase
      if (done) at_cyc = cyc;
      @(posedge clk);
      #1;
      t++;
      if (!done && t > 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL hs_timeout_%0d: got no ready in %0d cycles, expected a transfer", which, t);
        done = 1'b1;
      end
    end
  endtask

  task automatic drv_meta(input logic [META_W-1:0] m);
    int c;
    in_meta_if.data = m; in_meta_if.sop = 1'b1; in_meta_if.eop = 1'b1; in_meta_if.valid = 1'b1;
    wait_hs(0, c);
    drv_meta_cyc = c;
    in_meta_if.valid = 1'b0;
  endtask

  task automatic drv_usr(input int idx, input int nb);
    int c;
    ubeat_t u;
    for (int b = 0; b < nb && !abort; b++) begin
      u = mk_usr(idx, b, nb);
      in_usr_if.data = u.data; in_usr_if.sop = u.sop; in_usr_if.eop = u.eop; in_usr_if.valid = 1'b1;
      wait_hs(1, c);
    end
    in_usr_if.valid = 1'b0;
  endtask

  task automatic drv_pkt(input int idx, input int nb, input int emp);
    int c;
    pbeat_t p;
    for (int b = 0; b < nb && !abort; b++) begin
      p = mk_pkt(idx, b, nb, emp);
      in_pkt_if.data = p.data; in_pkt_if.sop = p.sop; in_pkt_if.eop = p.eop;
      in_pkt_if.empty = p.empty; in_pkt_if.valid = 1'b1;
      wait_hs(2, c);
    end
    in_pkt_if.valid = 1'b0;
  endtask

  task automatic send_packet(input int idx, input int nr, input int nb, input int emp);
    int rb;
    logic [META_W-1:0] m;
    rb = (nr + 31) / 32;
    m = {32'hA500_0000 + 32'(idx), 16'(nb), 16'(nr)};
    exp_in++;
    if (nr == 0) exp_drop++;
    else begin
      exp_fwd++;
      exp_rule += rb;
      q_meta.push_back(m);
      for (int b = 0; b < rb; b++) q_usr.push_back(mk_usr(idx, b, rb));
      for (int b = 0; b < nb; b++) q_pkt.push_back(mk_pkt(idx, b, nb, emp));
    end
    fork
      drv_meta(m);
      drv_usr(idx, rb);
      drv_pkt(idx, nb, emp);
    join
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_stats_in"},   520'(s_in),   520'(se(exp_in)));
    chk({tag, "_stats_drop"}, 520'(s_drop), 520'(se(exp_drop)));
    chk({tag, "_stats_fwd"},  520'(s_fwd),  520'(se(exp_fwd)));
    chk({tag, "_stats_rule"}, 520'(s_rule), 520'(se(exp_rule)));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_handshake"}, 520'({in_meta_if.ready, in_usr_if.ready, in_pkt_if.ready,
        out_meta_if.valid, out_usr_if.valid, out_pkt_if.valid}), 520'(0));
    chk({tag, "_meta_data"}, 520'(out_meta_if.data), 520'(0));
    chk({tag, "_pkt_data"}, 520'(out_pkt_if.data), 520'(0));
    chk({tag, "_stats"}, 520'({s_in, s_drop, s_fwd, s_rule}), 520'(0));
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((q_meta.size() + q_usr.size() + q_pkt.size()) != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk({tag, "_drain"}, 520'(q_meta.size() + q_usr.size() + q_pkt.size()), 520'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_in = 0; exp_drop = 0; exp_fwd = 0; exp_rule = 0;
  endtask

  // Global time limit
  initial begin
    #400000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "time limit");
  end

  // Directed scenarios
  initial begin
    int t;
    in_pkt_if.valid = 1'b0;  in_pkt_if.data = '0;  in_pkt_if.sop = 1'b0;  in_pkt_if.eop = 1'b0;  in_pkt_if.empty = '0;
    in_meta_if.valid = 1'b0; in_meta_if.data = '0; in_meta_if.sop = 1'b0; in_meta_if.eop = 1'b0; in_meta_if.empty = '0;
    in_usr_if.valid = 1'b0;  in_usr_if.data = '0;  in_usr_if.sop = 1'b0;  in_usr_if.eop = 1'b0;  in_usr_if.empty = '0;
    out_pkt_if.ready = 1'b1; out_meta_if.ready = 1'b1; out_usr_if.ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: forwarded packet, latency N+1 / N+2 / N+3,N+4
    meta_cyc.delete(); usr_cyc.delete(); pkt_cyc.delete();
    send_packet(1, 3, 2, 0);
    chk("s1_meta_lat", 520'(meta_cyc.size() > 0 ? meta_cyc[0] : -1), 520'(drv_meta_cyc + 1));
    chk("s1_rule_lat", 520'(usr_cyc.size() > 0 ? usr_cyc[0] : -1), 520'(drv_meta_cyc + 2));
    chk("s1_pkt0_lat", 520'(pkt_cyc.size() > 0 ? pkt_cyc[0] : -1), 520'(drv_meta_cyc + 3));
    chk("s1_pkt1_lat", 520'(pkt_cyc.size() > 1 ? pkt_cyc[1] : -1), 520'(drv_meta_cyc + 4));
    chk_stats("s1");

    // 2: dropped 4-beat packet
    pkt_rdy_cnt = 0;
    send_packet(2, 0, 4, 0);
    chk("s2_drop_ready_cycles", 520'(pkt_rdy_cnt), 520'(4));
    chk_stats("s2");

    // 3: two rule beats, 5-cycle stall on out_usr, single-beat packet empty=10
    usr_xfer_cnt = 0;
    usr_stall_cnt = 0;
    fork
      send_packet(3, 40, 1, 10);
      begin
        t = 0;
        while (usr_xfer_cnt < 1 && t < 200) begin
          @(posedge clk);
          t++;
        end
        hold_usr = 1'b1;
        repeat (5) @(posedge clk);
        hold_usr = 1'b0;
      end
    join
    chk("s3_stall_cycles", 520'(usr_stall_cnt), 520'(5));
    drain("s3");
    chk_stats("s3");

    // 4: 100 back-to-back packets, alternating 0/5 rules, random ready
    do_reset();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send_packet(100 + i, (i % 2 == 1) ? 5 : 0, 1 + (i % 3), i % 64);
    end
    drain("s4");
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    chk("s4_in_total",   520'(s_in),   520'(se(100)));
    chk("s4_drop_total", 520'(s_drop), 520'(se(50)));
    chk("s4_fwd_total",  520'(s_fwd),  520'(se(50)));
    chk("s4_rule_total", 520'(s_rule), 520'(se(50)));

    // 5: reset during beat 2 of a 4-beat forwarded packet
    @(posedge clk);
    #1;
    pkt_xfer_cnt = 0;
    sp_done = 1'b0;
    fork
      begin
        send_packet(200, 3, 4, 0);
        sp_done = 1'b1;
      end
    join_none
    t = 0;
    while (pkt_xfer_cnt < 1 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #2;
    rst_n = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    t = 0;
    while (!sp_done && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("s5_driver_abort", 520'(sp_done), 520'(1));
    in_pkt_if.valid = 1'b0; in_meta_if.valid = 1'b0; in_usr_if.valid = 1'b0;
    q_meta.delete(); q_usr.delete(); q_pkt.delete();
    abort = 1'b0;
    @(negedge clk);
    chk_reset_state("s5_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_in = 0; exp_drop = 0; exp_fwd = 0; exp_rule = 0;
    send_packet(201, 3, 2, 5);
    drain("s5");
    chk_stats("s5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
